fetch_queue_unit: RTL and testbench

//  Parametrised fetch stage: owns the PC, issues in-order requests to a variable-latency

---
 rtl/fetch_queue_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_queue_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests and queues returned instructions
// with their PCs. Optional build macro FETCH_PERF_EN adds stall/flush performance counters.
module fetch_queue_unit #(
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 4,
  parameter int PC_INC    = 2,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nHaltSig,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] instr_pc,
  output logic [DATA_W-1:0] pc_next,
`ifdef FETCH_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic              halted
);

  localparam int AW     = $clog2(BUF_DEPTH);
  localparam int PW     = AW + 1;
  localparam int DROP_W = 16;
  localparam logic [PW-1:0] DEPTH = PW'(BUF_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  // Pointers carry one extra bit so full and empty are distinguishable.
  // Entries in [head, fill) are filled; [fill, tail) await their response.
  logic [PW-1:0]       head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [DATA_W-1:0]   ent_pc_q  [BUF_DEPTH];
  logic [DATA_W-1:0]   ent_ins_q [BUF_DEPTH];

  logic [PW-1:0] count, unfilled, nfilled;
  logic          grant, rsp_any, rsp_live, pop;
  logic          unused_rpc0;

  assign unused_rpc0 = redirect_pc[0];

  assign count    = tail_q - head_q;
  assign unfilled = tail_q - fill_q;
  assign nfilled  = fill_q - head_q;

  assign imem_req  = (state_q == S_RUN) & (count < DEPTH) & ~redirect_valid & ~rst;
  assign imem_addr = pc_q;
  assign grant     = imem_req & imem_gnt;

  // A response either retires a pending discard or fills the oldest waiting entry;
  // one arriving with neither outstanding (e.g. after reset) is ignored.
  assign rsp_any  = imem_rvalid & ((drop_q != '0) | (unfilled != '0));
  assign rsp_live = imem_rvalid & (drop_q == '0) & (unfilled != '0);

  assign instr_valid = (nfilled != '0) & (state_q != S_HALT);
  assign pop         = instr_valid & instr_ready;
  assign halted      = (state_q == S_HALT);

  assign instr    = instr_valid ? ent_ins_q[head_q[AW-1:0]] : '0;
  assign instr_pc = instr_valid ? ent_pc_q[head_q[AW-1:0]]  : '0;
  assign pc_next  = instr_valid ? ent_pc_q[head_q[AW-1:0]] + DATA_W'(PC_INC) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (!nHaltSig) state_d = S_DRAIN;
      S_DRAIN: if (count == '0 && drop_q == '0) state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    head_d = head_q;
    fill_d = fill_q;
    tail_d = tail_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      // Everything still in flight for the old path must be swallowed on return.
      pc_d   = {redirect_pc[DATA_W-1:1], 1'b0};
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
      drop_d = drop_q + DROP_W'(unfilled) - DROP_W'(rsp_any);
    end else begin
      if (grant) begin
        pc_d   = pc_q + DATA_W'(PC_INC);
        tail_d = tail_q + 1'b1;
      end
      if (rsp_live) fill_d = fill_q + 1'b1;
      if (imem_rvalid && drop_q != '0) drop_d = drop_q - 1'b1;
      if (pop) head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= DATA_W'(RESET_PC);
      head_q  <= '0;
      fill_q  <= '0;
      tail_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      fill_q  <= fill_d;
      tail_q  <= tail_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid) begin
      if (grant)    ent_pc_q[tail_q[AW-1:0]]  <= pc_q;
      if (rsp_live) ent_ins_q[fill_q[AW-1:0]] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (instr_valid && !instr_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (redirect_valid && flush_q != '1)               flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: random memory latency, grants, backpressure,
// redirects, mid-run reset and halt, checked against a queue-level reference model.
`timescale 1ns/1ps
module tb_fetch_queue_unit;
  localparam int NCYC = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1, nHaltSig = 1'b1, redirect_valid = 1'b0;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, instr_ready = 1'b0;
  logic [15:0] redirect_pc = '0, imem_rdata = '0;
  logic        imem_req, instr_valid, halted;
  logic [15:0] imem_addr, instr, instr_pc, pc_next;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  always #5 clk = ~clk;

  fetch_queue_unit #(.DATA_W(16), .BUF_DEPTH(4), .PC_INC(2), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .nHaltSig(nHaltSig),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .pc_next(pc_next),
`ifdef FETCH_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .halted(halted)
  );

  // Expected queue entries (scoreboard) and memory transactions in flight.
  // kind: 0 = live, 1 = orphaned by redirect, 2 = orphaned by reset.
  typedef struct { logic [15:0] pc; bit filled; } ent_t;
  typedef struct { logic [15:0] addr; int due; int kind; } mreq_t;
  ent_t  exq[$];
  mreq_t pend[$];

  logic [15:0] m_pc = '0;
  int          m_state = 0;  // 0 run, 1 drain, 2 halted
  logic [31:0] m_stall = '0;
  logic [15:0] m_flush = '0;
  int          total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  function automatic bit rst_dead_pending();
    foreach (pend[i]) if (pend[i].kind == 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int redir_dead_count();
    int n = 0;
    foreach (pend[i]) if (pend[i].kind == 1) n++;
    return n;
  endfunction

  // Monitor: every accepted instruction must match the oldest expected entry.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk); #2;
      if (instr_valid === 1'b1 && instr_ready && !redirect_valid && !rst) begin
        if (exq.size() == 0) chk("pop_with_empty_model", 32'(exq.size()), 1);
        else begin
          e = exq.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr", instr, memf(e.pc));
          chk("pc_next", pc_next, 16'(e.pc + 16'd2));
        end
      end
    end
  end

  initial begin
    int    lat, ph, n_ent, n_dead;
    bit    rv, exp_req, exp_iv;
    mreq_t it;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      ph          = (c < 40) ? 0 : (c < 60) ? 1 : 2;
      rst         = (c < 2) || (c == 620);
      nHaltSig    = (c < 900);
      instr_ready = (ph == 0) ? 1'b1 : (ph == 1) ? (c >= 52) : ($urandom_range(0, 3) != 0);
      imem_gnt    = (ph == 2) ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (rst_dead_pending()) imem_gnt = 1'b0;
      lat = (ph == 0) ? 1 : $urandom_range(1, 4);
      redirect_valid = (c == 100) || (c == 300) || (ph == 2 && $urandom_range(0, 99) < 3);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 16'hFFF0 | 16'($urandom_range(0, 15));
        1:       redirect_pc = 16'h0101;
        default: redirect_pc = 16'($urandom);
      endcase
      if (c == 100) redirect_pc = 16'h0101;
      if (c == 300) redirect_pc = 16'hFFFB;
      rv = (pend.size() > 0) && (pend[0].due <= c) && (ph != 2 || $urandom_range(0, 4) != 0);
      imem_rvalid = rv;
      imem_rdata  = rv ? memf(pend[0].addr) : 16'($urandom);
      #1;
      exp_req = !rst && m_state == 0 && exq.size() < 4 && !redirect_valid;
      exp_iv  = m_state != 2 && exq.size() > 0 && exq[0].filled;
      n_ent   = exq.size();
      n_dead  = redir_dead_count();
      if (c > 0) begin
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, exp_iv);
        chk("halted", halted, m_state == 2);
`ifdef FETCH_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, 32'(m_flush));
`endif
      end
      #2;
      if (rst) begin
        if (rv) it = pend.pop_front();
        foreach (pend[i]) pend[i].kind = 2;
        exq.delete();
        m_pc = '0; m_state = 0; m_stall = '0; m_flush = '0;
      end else begin
        if (rv) begin
          it = pend.pop_front();
          if (it.kind == 0) begin
            for (int i = 0; i < exq.size(); i++)
              if (!exq[i].filled) begin exq[i].filled = 1'b1; break; end
          end
        end
        if (exp_req && imem_gnt) begin
          pend.push_back('{m_pc, c + lat, 0});
          exq.push_back('{m_pc, 1'b0});
          m_pc = m_pc + 16'd2;
        end
        if (exp_iv && !instr_ready && m_stall != '1) m_stall = m_stall + 1;
        if (redirect_valid) begin
          exq.delete();
          foreach (pend[i]) if (pend[i].kind == 0) pend[i].kind = 1;
          m_pc = {redirect_pc[15:1], 1'b0};
          if (m_flush != '1) m_flush = m_flush + 1;
        end
        if (m_state == 0 && !nHaltSig) m_state = 1;
        else if (m_state == 1 && n_ent == 0 && n_dead == 0) m_state = 2;
      end
    end

    @(negedge clk);
    redirect_valid = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0;
    #1;
    chk("halted_at_end", halted, 1);
    chk("no_req_when_halted", imem_req, 0);
    rst = 1'b1; nHaltSig = 1'b1;
    #1;
    chk("req_during_rst", imem_req, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_req", imem_req, 1);
`ifdef FETCH_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
